// File: rtl/nvme_doorbell_wrarb.sv
// Round-robin arbiter that turns single-outstanding doorbell write requests into
// 32-bit MMIO writes, waits for completion or timeout, then acks the winner.
module nvme_doorbell_wrarb #(
    parameter int num_req       = 2,
    parameter int timeout_width = 10
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [num_req-1:0]      req_wrvalid,
    input  logic [num_req*32-1:0]   req_wraddr,
    input  logic [num_req*16-1:0]   req_wrdata,
    output logic [num_req-1:0]      req_wrack,
    output logic                    db_pcie_valid,
    output logic [31:0]             db_pcie_addr,
    output logic [31:0]             db_pcie_data,
    output logic [3:0]              db_pcie_be,
    input  logic                    pcie_db_ready,
    input  logic                    pcie_db_done,
    output logic                    err_misalign,
    output logic                    err_timeout,
    input  logic                    err_clear,
    output logic                    db_busy
);

    localparam int IW = (num_req > 1) ? $clog2(num_req) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

    state_t                   state_reg, state_next;
    logic [IW-1:0]            rr_ptr_reg, rr_ptr_next;
    logic [IW-1:0]            grant_reg, grant_next;
    logic [timeout_width-1:0] cnt_reg, cnt_next;

    logic [num_req-1:0]       ack_next;
    logic                     valid_next;
    logic [31:0]              addr_next;
    logic [31:0]              data_next;
    logic [3:0]               be_next;
    logic                     misalign_next;
    logic                     timeout_next;
    logic                     busy_next;
    logic                     misalign_set;
    logic                     timeout_set;

    logic [31:0]              addr_arr [num_req];
    logic [15:0]              data_arr [num_req];
    logic [num_req-1:0]       upper;
    logic [num_req-1:0]       cand;
    logic [IW-1:0]            pick;

    // Requesters above the last winner take precedence; otherwise wrap to the lowest.
    genvar gi;
    generate
        for (gi = 0; gi < num_req; gi++) begin : g_req
            assign addr_arr[gi] = req_wraddr[32*gi +: 32];
            assign data_arr[gi] = req_wrdata[16*gi +: 16];
            assign upper[gi]    = req_wrvalid[gi] && (IW'(gi) > rr_ptr_reg);
        end
    endgenerate

    always_comb begin
        cand = (|upper) ? upper : req_wrvalid;
        pick = '0;
        for (int i = num_req - 1; i >= 0; i--) begin
            if (cand[i]) pick = IW'(i);
        end
    end

    always_comb begin
        state_next   = state_reg;
        rr_ptr_next  = rr_ptr_reg;
        grant_next   = grant_reg;
        cnt_next     = cnt_reg;
        ack_next     = '0;
        valid_next   = db_pcie_valid;
        addr_next    = db_pcie_addr;
        data_next    = db_pcie_data;
        misalign_set = 1'b0;
        timeout_set  = 1'b0;

        case (state_reg)
            IDLE: begin
                if (|req_wrvalid) begin
                    grant_next  = pick;
                    rr_ptr_next = pick;
                    if (addr_arr[pick][1:0] == 2'b00) begin
                        valid_next = 1'b1;
                        addr_next  = addr_arr[pick];
                        data_next  = {16'h0000, data_arr[pick]};
                        state_next = ISSUE;
                    end else begin
                        misalign_set = 1'b1;
                        ack_next     = num_req'(1) << pick;
                        state_next   = ACK;
                    end
                end
            end
            ISSUE: begin
                if (pcie_db_ready) begin
                    valid_next = 1'b0;
                    cnt_next   = '0;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                // A done coinciding with expiry wins, so no error in that case.
                if (pcie_db_done) begin
                    ack_next   = num_req'(1) << grant_reg;
                    state_next = ACK;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                    if (&cnt_next) begin
                        timeout_set = 1'b1;
                        ack_next    = num_req'(1) << grant_reg;
                        state_next  = ACK;
                    end
                end
            end
            ACK: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        be_next       = valid_next ? 4'hF : 4'h0;
        misalign_next = misalign_set | (err_misalign & ~err_clear);
        timeout_next  = timeout_set | (err_timeout & ~err_clear);
        busy_next     = (state_next != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            rr_ptr_reg    <= IW'(num_req - 1);
            grant_reg     <= '0;
            cnt_reg       <= '0;
            req_wrack     <= '0;
            db_pcie_valid <= 1'b0;
            db_pcie_addr  <= '0;
            db_pcie_data  <= '0;
            db_pcie_be    <= '0;
            err_misalign  <= 1'b0;
            err_timeout   <= 1'b0;
            db_busy       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            rr_ptr_reg    <= rr_ptr_next;
            grant_reg     <= grant_next;
            cnt_reg       <= cnt_next;
            req_wrack     <= ack_next;
            db_pcie_valid <= valid_next;
            db_pcie_addr  <= addr_next;
            db_pcie_data  <= data_next;
            db_pcie_be    <= be_next;
            err_misalign  <= misalign_next;
            err_timeout   <= timeout_next;
            db_busy       <= busy_next;
        end
    end

endmodule

// File: tb/tb_nvme_doorbell_wrarb.sv
// Scoreboard bench for nvme_doorbell_wrarb: requester and PCIe models drive the DUT,
// a negedge monitor pops expected writes/acks and compares.
module tb_nvme_doorbell_wrarb;
    localparam int NR = 2;
    localparam int TW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [NR-1:0] req_wrvalid = '0;
    logic [63:0]   req_wraddr = '0;
    logic [31:0]   req_wrdata = '0;
    logic [NR-1:0] req_wrack;
    logic          db_pcie_valid;
    logic [31:0]   db_pcie_addr;
    logic [31:0]   db_pcie_data;
    logic [3:0]    db_pcie_be;
    logic          pcie_db_ready = 1'b1;
    logic          pcie_db_done = 1'b0;
    logic          err_misalign;
    logic          err_timeout;
    logic          err_clear = 1'b0;
    logic          db_busy;

    typedef struct { logic [31:0] addr; logic [15:0] data; } item_t;
    typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;

    item_t      rq0[$];
    item_t      rq1[$];
    wr_t        exp_wr[$];
    logic [1:0] exp_ack[$];
    wr_t        w;
    logic [1:0] a;
    logic [1:0] ack_seen = '0;
    int         done_delay = 2;
    int         n_cmp = 0;
    int         n_bad = 0;

    nvme_doorbell_wrarb #(.num_req(NR), .timeout_width(TW)) dut (
        .clk(clk), .reset(reset),
        .req_wrvalid(req_wrvalid), .req_wraddr(req_wraddr), .req_wrdata(req_wrdata),
        .req_wrack(req_wrack),
        .db_pcie_valid(db_pcie_valid), .db_pcie_addr(db_pcie_addr),
        .db_pcie_data(db_pcie_data), .db_pcie_be(db_pcie_be),
        .pcie_db_ready(pcie_db_ready), .pcie_db_done(pcie_db_done),
        .err_misalign(err_misalign), .err_timeout(err_timeout), .err_clear(err_clear),
        .db_busy(db_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic push_wr(input logic [31:0] addr, input logic [15:0] data);
        wr_t e;
        e.addr = addr;
        e.data = {16'h0000, data};
        exp_wr.push_back(e);
    endtask

    task automatic push_req(input int r, input logic [31:0] addr, input logic [15:0] data);
        item_t it;
        it.addr = addr;
        it.data = data;
        if (r == 0) rq0.push_back(it);
        else rq1.push_back(it);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(rq0.size() == 0 && rq1.size() == 0 && exp_ack.size() == 0 && !db_busy) && n < budget);
        check("idle_reached", {31'b0, (n < budget)}, 32'd1);
    endtask

    task automatic wait_handshake(input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(db_pcie_valid && pcie_db_ready) && n < budget);
        check("handshake_seen", {31'b0, (n < budget)}, 32'd1);
    endtask

    task automatic pulse_clear();
        @(posedge clk); #1;
        err_clear = 1'b1;
        @(posedge clk); #1;
        err_clear = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ack"},   {30'b0, req_wrack}, 32'd0);
        check({tag, "_valid"}, {31'b0, db_pcie_valid}, 32'd0);
        check({tag, "_addr"},  db_pcie_addr, 32'd0);
        check({tag, "_data"},  db_pcie_data, 32'd0);
        check({tag, "_be"},    {28'b0, db_pcie_be}, 32'd0);
        check({tag, "_emis"},  {31'b0, err_misalign}, 32'd0);
        check({tag, "_etmo"},  {31'b0, err_timeout}, 32'd0);
        check({tag, "_busy"},  {31'b0, db_busy}, 32'd0);
    endtask

    // Requester model: holds the head item valid until its ack, then presents the next.
    always @(negedge clk) ack_seen <= req_wrack;

    initial begin
        forever begin
            @(posedge clk); #1;
            if (ack_seen[0] && rq0.size() > 0) void'(rq0.pop_front());
            if (ack_seen[1] && rq1.size() > 0) void'(rq1.pop_front());
            req_wrvalid[0] = (rq0.size() > 0);
            req_wrvalid[1] = (rq1.size() > 0);
            if (rq0.size() > 0) begin
                req_wraddr[31:0] = rq0[0].addr;
                req_wrdata[15:0] = rq0[0].data;
            end
            if (rq1.size() > 0) begin
                req_wraddr[63:32] = rq1[0].addr;
                req_wrdata[31:16] = rq1[0].data;
            end
        end
    end

    // PCIe model: done pulse done_delay cycles after each accepted write.
    initial begin
        int   timer;
        logic hs;
        timer = 0;
        forever begin
            @(negedge clk);
            hs = db_pcie_valid && pcie_db_ready;
            if (hs) timer = done_delay;
            @(posedge clk); #1;
            pcie_db_done = 1'b0;
            if (timer > 0) begin
                timer--;
                if (timer == 0) pcie_db_done = 1'b1;
            end
        end
    end

    // Monitor: compares every accepted write and every ack against the scoreboard.
    always @(negedge clk) begin
        if (db_pcie_valid && pcie_db_ready) begin
            $display("write addr=%h data=%h be=%h", db_pcie_addr, db_pcie_data, db_pcie_be);
            if (exp_wr.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_write: got addr %h, required no write", db_pcie_addr);
            end else begin
                w = exp_wr.pop_front();
                check("wr_addr", db_pcie_addr, w.addr);
                check("wr_data", db_pcie_data, w.data);
                check("wr_be", {28'b0, db_pcie_be}, 32'hF);
            end
        end
        if (req_wrack != '0) begin
            $display("ack %b", req_wrack);
            if (exp_ack.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_ack: got %b, required no ack", req_wrack);
            end else begin
                a = exp_ack.pop_front();
                check("ack", {30'b0, req_wrack}, {30'b0, a});
            end
        end
    end

    initial begin
        int n;

        // Reset state
        @(negedge clk);
        check_reset_outputs("rst");
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);

        // Single write: valid lands one cycle after the request is sampled
        push_req(0, 32'h0000_1000, 16'h0005);
        push_wr(32'h0000_1000, 16'h0005);
        exp_ack.push_back(2'b01);
        @(posedge clk); #1;
        @(negedge clk);
        check("single_valid_n", {31'b0, db_pcie_valid}, 32'd0);
        @(negedge clk);
        check("single_valid_n1", {31'b0, db_pcie_valid}, 32'd1);
        check("single_busy", {31'b0, db_busy}, 32'd1);
        wait_idle(50);

        // Backpressure: ready low for 5 valid cycles, handshake on the 6th
        pcie_db_ready = 1'b0;
        push_req(0, 32'h0000_2000, 16'h1234);
        push_wr(32'h0000_2000, 16'h1234);
        exp_ack.push_back(2'b01);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!db_pcie_valid && n < 10);
        for (int i = 0; i < 6; i++) begin
            check("bp_valid", {31'b0, db_pcie_valid}, 32'd1);
            check("bp_addr", db_pcie_addr, 32'h0000_2000);
            check("bp_data", db_pcie_data, 32'h0000_1234);
            if (i < 5) begin
                @(posedge clk); #1;
                if (i == 4) pcie_db_ready = 1'b1;
                @(negedge clk);
            end
        end
        @(negedge clk);
        check("bp_valid_drop", {31'b0, db_pcie_valid}, 32'd0);
        wait_idle(50);

        // Misaligned request from requester 1: ack without a PCIe write
        push_req(1, 32'h0000_1006, 16'h0077);
        exp_ack.push_back(2'b10);
        wait_idle(50);
        check("mis_set", {31'b0, err_misalign}, 32'd1);
        check("mis_no_tmo", {31'b0, err_timeout}, 32'd0);
        pulse_clear();
        check("mis_cleared", {31'b0, err_misalign}, 32'd0);

        // Round-robin: last winner was requester 1, so order is 0,1,0,1,0,1
        for (int i = 0; i < 3; i++) begin
            push_req(0, 32'h0000_3000 + 32'(4 * i), 16'hA000 + 16'(i));
            push_req(1, 32'h0000_4000 + 32'(4 * i), 16'hB000 + 16'(i));
            push_wr(32'h0000_3000 + 32'(4 * i), 16'hA000 + 16'(i));
            push_wr(32'h0000_4000 + 32'(4 * i), 16'hB000 + 16'(i));
            exp_ack.push_back(2'b01);
            exp_ack.push_back(2'b10);
        end
        wait_idle(300);

        // Timeout: done arrives long after expiry and must be ignored
        done_delay = 20;
        push_req(0, 32'h0000_5000, 16'h0055);
        push_wr(32'h0000_5000, 16'h0055);
        exp_ack.push_back(2'b01);
        wait_handshake(20);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!err_timeout && n < 40);
        check("tmo_latency", 32'(n), 32'd16);
        check("tmo_ack", {30'b0, req_wrack}, 32'd1);
        wait_idle(50);
        repeat (12) @(negedge clk);
        check("tmo_sticky", {31'b0, err_timeout}, 32'd1);
        pulse_clear();
        check("tmo_cleared", {31'b0, err_timeout}, 32'd0);

        // Done on the expiry cycle counts as done
        done_delay = 15;
        push_req(0, 32'h0000_5004, 16'h0056);
        push_wr(32'h0000_5004, 16'h0056);
        exp_ack.push_back(2'b01);
        wait_idle(60);
        check("tmo_edge_done", {31'b0, err_timeout}, 32'd0);

        // Reset in WAIT: after release requester 0 is regranted first
        done_delay = 2;
        push_req(1, 32'h0000_7100, 16'h0071);
        push_wr(32'h0000_7100, 16'h0071);
        exp_ack.push_back(2'b10);
        wait_idle(50);
        done_delay = 30;
        push_req(0, 32'h0000_6000, 16'h0066);
        push_req(1, 32'h0000_7000, 16'h0077);
        push_wr(32'h0000_6000, 16'h0066);
        exp_ack.push_back(2'b01);
        exp_ack.push_back(2'b10);
        wait_handshake(20);
        repeat (3) @(negedge clk);
        check("wait_busy", {31'b0, db_busy}, 32'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check_reset_outputs("midrst");
        done_delay = 2;
        push_wr(32'h0000_6000, 16'h0066);
        push_wr(32'h0000_7000, 16'h0077);
        @(posedge clk); #1;
        reset = 1'b0;
        wait_idle(100);

        check("leftover_writes", 32'(exp_wr.size()), 32'd0);
        check("leftover_acks", 32'(exp_ack.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got still running, required finish");
        $fatal(1, "bench time limit");
    end

endmodule
